wishbone_rr_arbiter: RTL and testbench

WISHBONE_RR_ARBITER -- requirements
Module: wishbone_rr_arbiter

---
 rtl/wishbone_rr_arbiter.sv | 130 +++++++++++++
 tb/tb_wishbone_rr_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_rr_arbiter.sv
// ============================================================================
// Module   : wishbone_rr_arbiter
// Purpose  : Round-robin arbiter connecting N Wishbone managers to one
//            subordinate, with a per-transaction timeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wishbone_rr_arbiter #(
  parameter int NUM_MANAGERS   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic [NUM_MANAGERS*32-1:0]   A_ADR_I,
  input  logic [NUM_MANAGERS*32-1:0]   A_DAT_I,
  input  logic [NUM_MANAGERS*4-1:0]    A_SEL_I,
  input  logic [NUM_MANAGERS-1:0]      A_WE_I,
  input  logic [NUM_MANAGERS-1:0]      A_STB_I,
  input  logic [NUM_MANAGERS-1:0]      A_CYC_I,
  output logic [NUM_MANAGERS*32-1:0]   A_DAT_O,
  output logic [NUM_MANAGERS-1:0]      A_ACK_O,
  output logic [NUM_MANAGERS-1:0]      A_ERR_O,
  input  logic [31:0]                  DAT_I,
  input  logic                         ACK_I,
  output logic [31:0]                  ADR_O,
  output logic [31:0]                  DAT_O,
  output logic [3:0]                   SEL_O,
  output logic                         WE_O,
  output logic                         STB_O,
  output logic                         CYC_O,
  output logic [NUM_MANAGERS-1:0]      GNT_O
);

  localparam int c_idx_w = $clog2(NUM_MANAGERS);
  localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_idx_w-1:0] c_idx_max  = c_idx_w'(NUM_MANAGERS - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                  r_state;
  logic [c_idx_w-1:0]      r_gidx;
  logic [c_idx_w-1:0]      r_last;
  logic [c_cnt_w-1:0]      r_cnt;
  logic [NUM_MANAGERS-1:0] r_gnt;

  logic [NUM_MANAGERS-1:0] w_req;
  logic                    w_busy;
  logic                    w_tmo;
  logic                    w_found;
  logic [c_idx_w-1:0]      w_pick;

  assign w_req  = A_STB_I & A_CYC_I;
  assign w_busy = (r_state == BUSY);
  // A released grant (CYC dropped) never reports an error, and ACK always wins.
  assign w_tmo  = w_busy && !ACK_I && A_CYC_I[r_gidx] && (r_cnt == c_cnt_last);
  assign GNT_O  = r_gnt;

  // Search upward from last+1 with wrap; the first requester found wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_last;
    for (int k = 1; k <= NUM_MANAGERS; k++) begin
      if (!w_found && w_req[(int'(r_last) + k) % NUM_MANAGERS]) begin
        w_found = 1'b1;
        w_pick  = c_idx_w'((int'(r_last) + k) % NUM_MANAGERS);
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_last  <= c_idx_max;
      r_gidx  <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state <= BUSY;
            r_gidx  <= w_pick;
            r_gnt   <= NUM_MANAGERS'(1) << w_pick;
            r_cnt   <= '0;
          end
        end
        BUSY: begin
          if (ACK_I || !A_CYC_I[r_gidx] || w_tmo) begin
            r_state <= IDLE;
            r_last  <= r_gidx;
            r_gnt   <= '0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Everything is gated by BUSY so an asynchronous reset silences the bus at once.
  always_comb begin
    ADR_O   = '0;
    DAT_O   = '0;
    SEL_O   = '0;
    WE_O    = 1'b0;
    STB_O   = 1'b0;
    CYC_O   = 1'b0;
    A_DAT_O = '0;
    A_ACK_O = '0;
    A_ERR_O = '0;
    if (w_busy) begin
      ADR_O                   = A_ADR_I[r_gidx*32 +: 32];
      DAT_O                   = A_DAT_I[r_gidx*32 +: 32];
      SEL_O                   = A_SEL_I[r_gidx*4 +: 4];
      WE_O                    = A_WE_I[r_gidx];
      STB_O                   = A_STB_I[r_gidx];
      CYC_O                   = A_CYC_I[r_gidx];
      A_DAT_O[r_gidx*32 +: 32] = DAT_I;
      A_ACK_O[r_gidx]          = ACK_I;
      A_ERR_O[r_gidx]          = w_tmo;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wishbone_rr_arbiter.sv
// Directed testbench for wishbone_rr_arbiter (4 managers, timeout of 4 cycles).
`default_nettype none

module tb_wishbone_rr_arbiter;

  logic         CLK = 1'b0;
  logic         nRST;
  logic [127:0] A_ADR_I, A_DAT_I;
  logic [15:0]  A_SEL_I;
  logic [3:0]   A_WE_I, A_STB_I, A_CYC_I;
  logic [127:0] A_DAT_O;
  logic [3:0]   A_ACK_O, A_ERR_O;
  logic [31:0]  DAT_I;
  logic         ACK_I;
  logic [31:0]  ADR_O, DAT_O;
  logic [3:0]   SEL_O;
  logic         WE_O, STB_O, CYC_O;
  logic [3:0]   GNT_O;

  int n_checks = 0;
  int n_errors = 0;

  wishbone_rr_arbiter #(.NUM_MANAGERS(4), .TIMEOUT_CYCLES(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .A_ADR_I(A_ADR_I), .A_DAT_I(A_DAT_I), .A_SEL_I(A_SEL_I),
    .A_WE_I(A_WE_I), .A_STB_I(A_STB_I), .A_CYC_I(A_CYC_I),
    .A_DAT_O(A_DAT_O), .A_ACK_O(A_ACK_O), .A_ERR_O(A_ERR_O),
    .DAT_I(DAT_I), .ACK_I(ACK_I),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O),
    .WE_O(WE_O), .STB_O(STB_O), .CYC_O(CYC_O), .GNT_O(GNT_O)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input logic [3:0] m);
    A_STB_I = m;
    A_CYC_I = m;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    set_req(4'b0000);
    ACK_I = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    set_req(4'b1111);
    ACK_I = 1'b1;
    tick();
    settle();
    n_checks++; if (GNT_O !== 4'b0000) begin n_errors++; $display("FAIL reset_gnt: got %b want 0000", GNT_O); end
    n_checks++; if (CYC_O !== 1'b0) begin n_errors++; $display("FAIL reset_cyc: got %b want 0", CYC_O); end
    n_checks++; if (A_ACK_O !== 4'b0000) begin n_errors++; $display("FAIL reset_ack: got %b want 0000", A_ACK_O); end
    n_checks++; if (ADR_O !== 32'h0) begin n_errors++; $display("FAIL reset_adr: got %h want 0", ADR_O); end
    // ACK from the subordinate while idle must not reach any manager
    set_req(4'b0000);
    nRST = 1'b1;
    tick();
    settle();
    n_checks++; if (A_ACK_O !== 4'b0000) begin n_errors++; $display("FAIL idle_ack_ignored: got %b want 0000", A_ACK_O); end
    n_checks++; if (GNT_O !== 4'b0000) begin n_errors++; $display("FAIL idle_gnt: got %b want 0000", GNT_O); end
    ACK_I = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    set_req(4'b0101);
    DAT_I = 32'hCAFE_0001;
    settle();
    n_checks++; if (GNT_O !== 4'b0000 || CYC_O !== 1'b0) begin n_errors++; $display("FAIL basic_latency: got gnt=%b cyc=%b want 0000/0", GNT_O, CYC_O); end
    tick();
    settle();
    n_checks++; if (GNT_O !== 4'b0001) begin n_errors++; $display("FAIL basic_gnt0: got %b want 0001", GNT_O); end
    n_checks++; if (ADR_O !== 32'h1000_0000 || DAT_O !== 32'hD000_0000) begin n_errors++; $display("FAIL basic_mux0: got adr=%h dat=%h want 10000000/d0000000", ADR_O, DAT_O); end
    n_checks++; if (SEL_O !== 4'h1 || WE_O !== 1'b0 || STB_O !== 1'b1 || CYC_O !== 1'b1) begin n_errors++; $display("FAIL basic_ctl0: got sel=%h we=%b stb=%b cyc=%b want 1/0/1/1", SEL_O, WE_O, STB_O, CYC_O); end
    ACK_I = 1'b1;
    settle();
    n_checks++; if (A_ACK_O !== 4'b0001) begin n_errors++; $display("FAIL basic_ack0: got %b want 0001", A_ACK_O); end
    n_checks++; if (A_DAT_O !== {96'h0, 32'hCAFE_0001}) begin n_errors++; $display("FAIL basic_rdata0: got %h want %h", A_DAT_O, {96'h0, 32'hCAFE_0001}); end
    tick();
    ACK_I = 1'b0;
    set_req(4'b0100);
    DAT_I = 32'hCAFE_0002;
    settle();
    n_checks++; if (GNT_O !== 4'b0000) begin n_errors++; $display("FAIL basic_gap: got %b want 0000", GNT_O); end
    tick();
    settle();
    n_checks++; if (GNT_O !== 4'b0100) begin n_errors++; $display("FAIL basic_gnt2: got %b want 0100", GNT_O); end
    n_checks++; if (ADR_O !== 32'h1000_0002 || SEL_O !== 4'h3) begin n_errors++; $display("FAIL basic_mux2: got adr=%h sel=%h want 10000002/3", ADR_O, SEL_O); end
    ACK_I = 1'b1;
    settle();
    n_checks++; if (A_ACK_O !== 4'b0100 || A_DAT_O !== {32'h0, 32'hCAFE_0002, 64'h0}) begin n_errors++; $display("FAIL basic_ack2: got ack=%b dat=%h want 0100", A_ACK_O, A_DAT_O); end
    tick();
    ACK_I = 1'b0;
    set_req(4'b0000);
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [0:9];
    exp_g = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
    do_reset();
    set_req(4'b1111);
    ACK_I = 1'b1;
    for (int k = 0; k < 10; k++) begin
      settle();
      n_checks++; if (GNT_O !== exp_g[k]) begin n_errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, GNT_O, exp_g[k]); end
      n_checks++; if (A_ACK_O !== exp_g[k] || CYC_O !== (|exp_g[k])) begin n_errors++; $display("FAIL rr_ack[%0d]: got ack=%b cyc=%b want %b/%b", k, A_ACK_O, CYC_O, exp_g[k], |exp_g[k]); end
      tick();
    end
    set_req(4'b0000);
    ACK_I = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    set_req(4'b0010);
    settle();
    tick();
    for (int b = 1; b <= 4; b++) begin
      settle();
      n_checks++; if (GNT_O !== 4'b0010 || CYC_O !== 1'b1) begin n_errors++; $display("FAIL tmo_busy[%0d]: got gnt=%b cyc=%b want 0010/1", b, GNT_O, CYC_O); end
      n_checks++; if (A_ERR_O !== ((b == 4) ? 4'b0010 : 4'b0000)) begin n_errors++; $display("FAIL tmo_err[%0d]: got %b want %b", b, A_ERR_O, (b == 4) ? 4'b0010 : 4'b0000); end
      tick();
    end
    set_req(4'b0000);
    settle();
    n_checks++; if (CYC_O !== 1'b0 || GNT_O !== 4'b0000 || A_ERR_O !== 4'b0000) begin n_errors++; $display("FAIL tmo_release: got cyc=%b gnt=%b err=%b want 0/0000/0000", CYC_O, GNT_O, A_ERR_O); end
    tick();
  endtask

  task automatic test_ack_at_timeout();
    set_req(4'b0010);
    settle();
    tick();
    for (int b = 1; b <= 4; b++) begin
      ACK_I = (b == 4);
      settle();
      n_checks++; if (A_ERR_O !== 4'b0000) begin n_errors++; $display("FAIL ackwin_err[%0d]: got %b want 0000", b, A_ERR_O); end
      n_checks++; if (A_ACK_O !== ((b == 4) ? 4'b0010 : 4'b0000) || GNT_O !== 4'b0010) begin n_errors++; $display("FAIL ackwin_ack[%0d]: got ack=%b gnt=%b", b, A_ACK_O, GNT_O); end
      tick();
    end
    ACK_I = 1'b0;
    set_req(4'b0000);
    settle();
    n_checks++; if (GNT_O !== 4'b0000) begin n_errors++; $display("FAIL ackwin_idle: got %b want 0000", GNT_O); end
    tick();
  endtask

  task automatic test_cyc_drop();
    do_reset();
    set_req(4'b1000);
    settle();
    tick();
    settle();
    n_checks++; if (GNT_O !== 4'b1000 || CYC_O !== 1'b1 || ADR_O !== 32'h1000_0003) begin n_errors++; $display("FAIL drop_gnt3: got gnt=%b cyc=%b adr=%h", GNT_O, CYC_O, ADR_O); end
    tick();
    A_STB_I = 4'b1101;
    A_CYC_I = 4'b0101;
    settle();
    n_checks++; if (GNT_O !== 4'b1000 || CYC_O !== 1'b0 || STB_O !== 1'b1) begin n_errors++; $display("FAIL drop_follow: got gnt=%b cyc=%b stb=%b want 1000/0/1", GNT_O, CYC_O, STB_O); end
    n_checks++; if (A_ACK_O !== 4'b0000 || A_ERR_O !== 4'b0000) begin n_errors++; $display("FAIL drop_noresp: got ack=%b err=%b want 0000/0000", A_ACK_O, A_ERR_O); end
    tick();
    settle();
    n_checks++; if (GNT_O !== 4'b0000) begin n_errors++; $display("FAIL drop_idle: got %b want 0000", GNT_O); end
    tick();
    settle();
    n_checks++; if (GNT_O !== 4'b0001) begin n_errors++; $display("FAIL drop_next: got %b want 0001", GNT_O); end
    ACK_I = 1'b1;
    tick();
    ACK_I = 1'b0;
    set_req(4'b0000);
    tick();
  endtask

  task automatic test_async_reset();
    set_req(4'b0010);
    settle();
    tick();
    settle();
    n_checks++; if (GNT_O !== 4'b0010 || WE_O !== 1'b1 || CYC_O !== 1'b1) begin n_errors++; $display("FAIL arst_pre: got gnt=%b we=%b cyc=%b want 0010/1/1", GNT_O, WE_O, CYC_O); end
    nRST = 1'b0;
    #1;
    n_checks++; if (CYC_O !== 1'b0 || STB_O !== 1'b0 || WE_O !== 1'b0 || GNT_O !== 4'b0000) begin n_errors++; $display("FAIL arst_immediate: got cyc=%b stb=%b we=%b gnt=%b want all 0", CYC_O, STB_O, WE_O, GNT_O); end
    set_req(4'b0011);
    tick();
    settle();
    n_checks++; if (GNT_O !== 4'b0000) begin n_errors++; $display("FAIL arst_held: got %b want 0000", GNT_O); end
    nRST = 1'b1;
    settle();
    n_checks++; if (GNT_O !== 4'b0000) begin n_errors++; $display("FAIL arst_no_early_grant: got %b want 0000", GNT_O); end
    tick();
    settle();
    n_checks++; if (GNT_O !== 4'b0001 || ADR_O !== 32'h1000_0000) begin n_errors++; $display("FAIL arst_first: got gnt=%b adr=%h want 0001/10000000", GNT_O, ADR_O); end
    ACK_I = 1'b1;
    tick();
    ACK_I = 1'b0;
    set_req(4'b0000);
    tick();
  endtask

  initial begin
    nRST = 1'b0;
    ACK_I = 1'b0;
    DAT_I = 32'h0;
    set_req(4'b0000);
    for (int i = 0; i < 4; i++) begin
      A_ADR_I[i*32 +: 32] = 32'h1000_0000 + i;
      A_DAT_I[i*32 +: 32] = 32'hD000_0000 + i;
      A_SEL_I[i*4 +: 4]   = 4'(i + 1);
      A_WE_I[i]           = 1'(i % 2);
    end
    test_reset();
    test_basic();
    test_round_robin();
    test_timeout();
    test_ack_at_timeout();
    test_cyc_drop();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
